// File: rtl/tv80_reg_xfer.sv
// Save-state/debug sequencer for the TV80 register file: freezes the core at an
// instruction boundary and streams selected register pairs out (dump) or in (load).
`timescale 1ns/1ps

module tv80_reg_xfer #(
  parameter int NPAIRS  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cpu_cen_in,
  input  logic       cpu_boundary,
  output logic       cpu_cen_out,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_load,
  input  logic [7:0] cmd_mask,
  input  logic [2:0] core_addra,
  input  logic [7:0] core_dih,
  input  logic [7:0] core_dil,
  input  logic       core_weh,
  input  logic       core_wel,
  input  logic [2:0] core_addrc,
  output logic [2:0] rf_addra,
  output logic [7:0] rf_dih,
  output logic [7:0] rf_dil,
  output logic       rf_weh,
  output logic       rf_wel,
  output logic       rf_cen,
  output logic [2:0] rf_addrc,
  input  logic [7:0] rf_doch,
  input  logic [7:0] rf_docl,
  output logic [7:0] dout_data,
  output logic       dout_valid,
  input  logic       dout_ready,
  input  logic [7:0] din_data,
  input  logic       din_valid,
  output logic       din_ready,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [3:0] IDX_END = 4'(NPAIRS);
  localparam logic [7:0] CNT_END = 8'(TIMEOUT);

  typedef enum logic [3:0] {
    S_IDLE, S_WAIT_SYNC, S_SEL, S_DUMP_H, S_DUMP_L,
    S_LOAD_H, S_LOAD_L, S_WR, S_DONE
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] idx;
  logic [7:0] cnt;
  logic       load_r;
  logic [7:0] mask_r;
  logic       frozen;
  logic [7:0] hold;
  logic [7:0] low;

  logic [7:0] cnt_inc;
  logic       sel_end;
  logic       sel_hit;
  logic       pass;

  assign cnt_inc = cnt + 8'd1;
  assign sel_end = (idx >= IDX_END);
  assign sel_hit = mask_r[idx[2:0]];

  // A command that never froze the core (empty mask or sync timeout) keeps the
  // core running through DONE, so its register writes must still reach the file.
  assign pass = (state == S_IDLE) || (state == S_WAIT_SYNC) ||
                ((state == S_DONE) && !frozen);

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its peers regardless of statement order.
  always_ff @(posedge clk) begin
    state <= state_nxt;
    if (reset) begin
      state  <= S_IDLE;
      idx    <= '0;
      cnt    <= '0;
      load_r <= 1'b0;
      mask_r <= '0;
      frozen <= 1'b0;
      err    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (cmd_valid) begin
          load_r <= cmd_load;
          mask_r <= cmd_mask;
          err    <= 1'b0;
          frozen <= 1'b0;
          idx    <= '0;
          cnt    <= '0;
        end
        S_WAIT_SYNC: begin
          if (cpu_boundary) begin
            frozen <= 1'b1;
          end else begin
            cnt <= cnt_inc;
            if (cnt_inc == CNT_END) err <= 1'b1;
          end
        end
        S_SEL:    if (!sel_end && !sel_hit) idx <= idx + 4'd1;
        S_DUMP_L: if (dout_ready) idx <= idx + 4'd1;
        S_WR:     idx <= idx + 4'd1;
        default: ;
      endcase
    end
  end

  // NOTE: byte holding registers carry data only; their contents are never
  // observed before being written, so they are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (state == S_LOAD_H && din_valid) hold <= din_data;
    if (state == S_LOAD_L && din_valid) low  <= din_data;
  end

  // NOTE: every combinational output gets a default first so no path through
  // the case statements can leave a value unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (cmd_valid) state_nxt = (cmd_mask == 8'h00) ? S_DONE : S_WAIT_SYNC;
      S_WAIT_SYNC: begin
        if (cpu_boundary)           state_nxt = S_SEL;
        else if (cnt_inc == CNT_END) state_nxt = S_DONE;
      end
      S_SEL: begin
        if (sel_end)      state_nxt = S_DONE;
        else if (sel_hit) state_nxt = load_r ? S_LOAD_H : S_DUMP_H;
      end
      S_DUMP_H: if (dout_ready) state_nxt = S_DUMP_L;
      S_DUMP_L: if (dout_ready) state_nxt = S_SEL;
      S_LOAD_H: if (din_valid)  state_nxt = S_LOAD_L;
      S_LOAD_L: if (din_valid)  state_nxt = S_WR;
      S_WR:     state_nxt = S_SEL;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cpu_cen_out = 1'b0;
    rf_addra    = idx[2:0];
    rf_dih      = hold;
    rf_dil      = low;
    rf_weh      = 1'b0;
    rf_wel      = 1'b0;
    rf_cen      = 1'b0;
    rf_addrc    = idx[2:0];
    dout_data   = 8'h00;
    dout_valid  = 1'b0;
    din_ready   = 1'b0;

    if (pass) begin
      rf_addra    = core_addra;
      rf_dih      = core_dih;
      rf_dil      = core_dil;
      rf_weh      = core_weh;
      rf_wel      = core_wel;
      rf_cen      = cpu_cen_in;
      rf_addrc    = core_addrc;
      // The freeze takes effect in the very cycle the boundary is seen.
      cpu_cen_out = (state == S_WAIT_SYNC) ? (cpu_cen_in & ~cpu_boundary) : cpu_cen_in;
    end

    case (state)
      S_DUMP_H: begin
        dout_valid = 1'b1;
        dout_data  = rf_doch;
      end
      S_DUMP_L: begin
        dout_valid = 1'b1;
        dout_data  = rf_docl;
      end
      S_LOAD_H, S_LOAD_L: din_ready = 1'b1;
      S_WR: begin
        rf_weh = 1'b1;
        rf_wel = 1'b1;
        rf_cen = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_tv80_reg_xfer.sv
// Directed bench for tv80_reg_xfer with a behavioural register-file model
// (async read on addrc, clocked write on addra when cen and byte enables are set).
`timescale 1ns/1ps

module tb_tv80_reg_xfer;

  logic       clk = 1'b0;
  logic       reset;
  logic       cpu_cen_in, cpu_boundary, cpu_cen_out;
  logic       cmd_valid, cmd_ready, cmd_load;
  logic [7:0] cmd_mask;
  logic [2:0] core_addra, core_addrc;
  logic [7:0] core_dih, core_dil;
  logic       core_weh, core_wel;
  logic [2:0] rf_addra, rf_addrc;
  logic [7:0] rf_dih, rf_dil, rf_doch, rf_docl;
  logic       rf_weh, rf_wel, rf_cen;
  logic [7:0] dout_data, din_data;
  logic       dout_valid, dout_ready, din_valid, din_ready;
  logic       busy, done, err;

  always #5 clk = ~clk;

  tv80_reg_xfer #(.NPAIRS(8), .TIMEOUT(255)) dut (
    .clk(clk), .reset(reset),
    .cpu_cen_in(cpu_cen_in), .cpu_boundary(cpu_boundary), .cpu_cen_out(cpu_cen_out),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load(cmd_load), .cmd_mask(cmd_mask),
    .core_addra(core_addra), .core_dih(core_dih), .core_dil(core_dil),
    .core_weh(core_weh), .core_wel(core_wel), .core_addrc(core_addrc),
    .rf_addra(rf_addra), .rf_dih(rf_dih), .rf_dil(rf_dil), .rf_weh(rf_weh),
    .rf_wel(rf_wel), .rf_cen(rf_cen), .rf_addrc(rf_addrc),
    .rf_doch(rf_doch), .rf_docl(rf_docl),
    .dout_data(dout_data), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .din_data(din_data), .din_valid(din_valid), .din_ready(din_ready),
    .busy(busy), .done(done), .err(err)
  );

  // Register-file model
  logic [7:0] rf_h [8];
  logic [7:0] rf_l [8];
  always @(posedge clk) begin
    if (rf_cen && rf_weh) rf_h[rf_addra] <= rf_dih;
    if (rf_cen && rf_wel) rf_l[rf_addra] <= rf_dil;
  end
  assign rf_doch = rf_h[rf_addrc];
  assign rf_docl = rf_l[rf_addrc];

  logic [7:0] exp_h [8];
  logic [7:0] exp_l [8];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic int pair_mismatches();
    int m = 0;
    for (int i = 0; i < 8; i++)
      if (rf_h[i] !== exp_h[i] || rf_l[i] !== exp_l[i]) m++;
    return m;
  endfunction

  // Results gathered by run_cmd
  logic [7:0] got_q [$];
  logic [7:0] din_q [$];
  int         din_idx;
  int         done_cycle, first_valid_cycle, cen_low_cycles, cen_bad_after_bnd;
  int         stab_bad, ready_while_busy, wr_count;
  logic [2:0] wr_addr;
  logic [7:0] wr_h, wr_l;
  logic       err_at_done;

  task automatic core_write(input logic [2:0] a, input logic [7:0] h, input logic [7:0] l);
    @(posedge clk); #1;
    core_addra = a; core_dih = h; core_dil = l; core_weh = 1'b1; core_wel = 1'b1;
    @(posedge clk); #1;
    core_weh = 1'b0; core_wel = 1'b0;
    exp_h[a] = h; exp_l[a] = l;
  endtask

  // Issues one command and follows it cycle by cycle until done (or until the
  // load stream is exhausted when stop_din is set). Cycle 1 is the first cycle
  // after the accept edge.
  task automatic run_cmd(input logic ld, input logic [7:0] mask, input int bnd_at,
                         input bit stall, input bit junk, input bit stop_din, input int budget);
    int cycle;
    bit fin;
    logic pv, pr;
    logic [7:0] pd;
    got_q.delete();
    din_idx = 0; done_cycle = -1; first_valid_cycle = -1; cen_low_cycles = 0;
    cen_bad_after_bnd = 0; stab_bad = 0; ready_while_busy = 0; wr_count = 0;
    wr_addr = '0; wr_h = '0; wr_l = '0; err_at_done = 1'bx;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_load = ld; cmd_mask = mask;
    cpu_boundary = 1'b0; dout_ready = 1'b0; din_valid = 1'b0;
    @(negedge clk);
    check("accept_ready", cmd_ready, 1);
    cycle = 0; fin = 0; pv = 0; pr = 0; pd = '0;
    while (!fin && cycle < budget) begin
      @(posedge clk); #1;
      cycle++;
      cmd_valid    = junk;
      if (junk) cmd_mask = 8'hFF;
      cpu_boundary = (bnd_at > 0 && cycle >= bnd_at);
      dout_ready   = stall ? (cycle % 3 == 0) : 1'b1;
      din_valid    = (din_idx < din_q.size());
      din_data     = din_valid ? din_q[din_idx] : 8'h00;
      @(negedge clk);
      if (busy && cmd_ready) ready_while_busy++;
      if (!cpu_cen_out) cen_low_cycles++;
      if (bnd_at > 0 && cycle >= bnd_at && cpu_cen_out) cen_bad_after_bnd++;
      if (pv && !pr && (!dout_valid || dout_data !== pd)) stab_bad++;
      if (dout_valid && first_valid_cycle < 0) first_valid_cycle = cycle;
      if (dout_valid && dout_ready) got_q.push_back(dout_data);
      if (din_valid && din_ready) din_idx++;
      if (busy && rf_cen && (rf_weh || rf_wel)) begin
        wr_count++; wr_addr = rf_addra; wr_h = rf_dih; wr_l = rf_dil;
      end
      pv = dout_valid; pr = dout_ready; pd = dout_data;
      if (done) begin
        done_cycle = cycle; err_at_done = err; fin = 1;
      end else if (stop_din && din_idx == din_q.size()) begin
        fin = 1;
      end
    end
    cmd_valid = 1'b0;
    cpu_boundary = 1'b0;
    if (!stop_din) begin
      din_valid = 1'b0; dout_ready = 1'b0;
    end
  endtask

  function automatic logic [31:0] got_word();
    logic [31:0] w = '0;
    for (int i = 0; i < got_q.size() && i < 4; i++) w = {w[23:0], got_q[i]};
    return w;
  endfunction

  typedef struct {
    logic       cen_in;
    logic       bnd;
    logic [2:0] addra;
    logic [7:0] dih;
    logic [7:0] dil;
    logic       weh;
    logic       wel;
    logic [2:0] addrc;
    logic [25:0] exp_out;  // {cpu_cen_out, rf_cen, rf_addra, rf_dih, rf_dil, rf_weh, rf_wel, rf_addrc}
  } pt_vec_t;

  pt_vec_t pt [4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pt[0] = '{1'b1, 1'b0, 3'd5, 8'h3C, 8'hC3, 1'b0, 1'b0, 3'd2,
              {1'b1, 1'b1, 3'd5, 8'h3C, 8'hC3, 1'b0, 1'b0, 3'd2}};
    pt[1] = '{1'b0, 1'b0, 3'd1, 8'hFF, 8'h00, 1'b1, 1'b0, 3'd7,
              {1'b0, 1'b0, 3'd1, 8'hFF, 8'h00, 1'b1, 1'b0, 3'd7}};
    pt[2] = '{1'b1, 1'b1, 3'd6, 8'h81, 8'h18, 1'b0, 1'b1, 3'd4,
              {1'b1, 1'b1, 3'd6, 8'h81, 8'h18, 1'b0, 1'b1, 3'd4}};
    pt[3] = '{1'b0, 1'b1, 3'd0, 8'h00, 8'h5A, 1'b1, 1'b1, 3'd0,
              {1'b0, 1'b0, 3'd0, 8'h00, 8'h5A, 1'b1, 1'b1, 3'd0}};

    reset = 1'b1; cpu_cen_in = 1'b1; cpu_boundary = 1'b0;
    cmd_valid = 1'b0; cmd_load = 1'b0; cmd_mask = 8'h00;
    core_addra = '0; core_dih = '0; core_dil = '0; core_weh = 1'b0; core_wel = 1'b0;
    core_addrc = '0; dout_ready = 1'b0; din_data = '0; din_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_outputs", {cmd_ready, busy, done, err, dout_valid, din_ready}, 6'b100000);

    // Passthrough in IDLE (boundary has no effect while idle)
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      cpu_cen_in = pt[i].cen_in; cpu_boundary = pt[i].bnd;
      core_addra = pt[i].addra; core_dih = pt[i].dih; core_dil = pt[i].dil;
      core_weh = pt[i].weh; core_wel = pt[i].wel; core_addrc = pt[i].addrc;
      @(negedge clk);
      check($sformatf("pt%0d", i),
            {cpu_cen_out, rf_cen, rf_addra, rf_dih, rf_dil, rf_weh, rf_wel, rf_addrc},
            pt[i].exp_out);
    end
    @(posedge clk); #1;
    cpu_cen_in = 1'b1; cpu_boundary = 1'b0; core_weh = 1'b0; core_wel = 1'b0;

    // Preload every pair through the core port
    for (int i = 0; i < 8; i++) core_write(3'(i), 8'h60 + 8'(i), 8'h70 + 8'(i));
    core_write(3'd0, 8'h12, 8'h34);
    core_write(3'd2, 8'hAB, 8'hCD);
    @(negedge clk);
    check("preload", pair_mismatches(), 0);

    // Dump mask 0x05, no stalls, boundary seen in cycle 3
    run_cmd(1'b0, 8'h05, 3, 1'b0, 1'b0, 1'b0, 100);
    check("dump_bytes",   got_word(), 32'h1234ABCD);
    check("dump_nbytes",  got_q.size(), 4);
    check("dump_latency", first_valid_cycle, 5);
    check("dump_done",    done_cycle, 17);
    check("dump_err",     err_at_done, 0);
    check("dump_cen_hi",  cen_bad_after_bnd, 0);
    check("dump_cen_lo",  cen_low_cycles, 15);
    check("dump_nowr",    wr_count, 0);

    // Same dump with dout_ready high one cycle in three and junk commands while busy
    run_cmd(1'b0, 8'h05, 2, 1'b1, 1'b1, 1'b0, 200);
    check("stall_bytes",  got_word(), 32'h1234ABCD);
    check("stall_nbytes", got_q.size(), 4);
    check("stall_stable", stab_bad, 0);
    check("stall_busy_rdy", ready_while_busy, 0);
    check("stall_done_seen", done_cycle > 0, 1);
    @(negedge clk);
    check("stall_idle", {busy, cmd_ready}, 2'b01);

    // Load mask 0x80
    din_q = '{8'hAA, 8'h55};
    run_cmd(1'b1, 8'h80, 1, 1'b0, 1'b0, 1'b0, 100);
    exp_h[7] = 8'hAA; exp_l[7] = 8'h55;
    check("load_wr_count", wr_count, 1);
    check("load_wr_port", {wr_addr, wr_h, wr_l}, {3'd7, 8'hAA, 8'h55});
    check("load_din_taken", din_idx, 2);
    check("load_done_seen", done_cycle > 0, 1);
    check("load_pairs", pair_mismatches(), 0);

    // Sync timeout: boundary never arrives
    din_q.delete();
    run_cmd(1'b0, 8'h01, 0, 1'b0, 1'b0, 1'b0, 300);
    check("to_done", done_cycle, 256);
    check("to_err",  err_at_done, 1);
    check("to_nofreeze", cen_low_cycles, 0);
    @(negedge clk);
    check("to_err_sticky", {err, cmd_ready}, 2'b11);

    // Empty mask: finishes immediately and clears the sticky error
    run_cmd(1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b0, 20);
    check("m0_done", done_cycle, 1);
    check("m0_err",  err_at_done, 0);
    check("m0_nofreeze", cen_low_cycles, 0);

    // Load mask 0x03, reset after pair0 written and pair1 high byte taken
    din_q = '{8'h5A, 8'hA5, 8'h77};
    run_cmd(1'b1, 8'h03, 1, 1'b0, 1'b0, 1'b1, 100);
    check("rl_one_wr", wr_count, 1);
    @(posedge clk); #1;
    reset = 1'b1; din_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    exp_h[0] = 8'h5A; exp_l[0] = 8'hA5;
    check("rl_idle", {busy, cmd_ready, din_ready, done}, 4'b0100);
    check("rl_cen_pass", cpu_cen_out, 1);
    check("rl_pair0", {rf_h[0], rf_l[0]}, 16'h5AA5);
    check("rl_pair1", {rf_h[1], rf_l[1]}, {exp_h[1], exp_l[1]});
    check("rl_pairs", pair_mismatches(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
